// File: rtl/adc_sample_pacer.sv
// adc_sample_pacer
//   Transmit side of the ready/x sample interface. Raw unsigned offset-binary
//   ADC conversions are converted to signed values. They are block-averaged by
//   DECIM and scaled to 16 bits. The results are buffered in a small FIFO, and
//   one word is emitted with a 1-cycle ready_out strobe exactly every PERIOD
//   clocks once the FIFO has primed to half full.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous reset, active-low
//   adc_valid_in    1-cycle strobe, adc_data_in valid
//   adc_data_in     unsigned offset-binary conversion (IN_W bits)
//   ready_out       1-cycle strobe, x_out valid on the same cycle
//   x_out           signed 16-bit sample, held between strobes
//   fifo_level_out  current FIFO occupancy
//   overflow_out    sticky, a decimated sample was dropped (FIFO full)
//   underflow_out   sticky, a strobe fired with the FIFO empty
//
// Build option
//   PACER_ZERO_FILL_EN  defined: an underflow strobe emits 0.
//                       undefined: an underflow strobe repeats the last emitted value.

module adc_sample_pacer #(
  parameter int unsigned PERIOD     = 128,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned IN_W       = 12
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        adc_valid_in,
  input  logic [IN_W-1:0]             adc_data_in,
  output logic                        ready_out,
  output logic [15:0]                 x_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_out,
  output logic                        overflow_out,
  output logic                        underflow_out
);

  localparam int unsigned DW    = $clog2(DECIM);
  localparam int unsigned ACC_W = IN_W + DW;
  localparam int unsigned CW    = (DW > 0) ? DW : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // Only one of these is non-zero: left shift up to 16 bits, or right shift down.
  localparam int unsigned SHL   = (ACC_W <= 16) ? (16 - ACC_W) : 0;
  localparam int unsigned SHR   = (ACC_W > 16) ? (ACC_W - 16) : 0;

  localparam logic [CW-1:0] DCNT_LAST = CW'(DECIM - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_PRIME = LW'(FIFO_DEPTH / 2);

  typedef enum logic {S_PRIME, S_RUN} state_t;

  // ---------------------------------------------------------------------------
  // Decimator: signed conversion, accumulate DECIM samples, scale to 16 bits
  // ---------------------------------------------------------------------------
  logic signed [IN_W-1:0]  s_c;
  logic signed [ACC_W-1:0] sum_c;
  logic signed [31:0]      sum_ext_c;
  logic signed [31:0]      scaled_c;
  logic                    last_c;

  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           dcnt;
  logic                    push_q;
  logic [15:0]             push_data;

  // Subtracting mid-scale from offset-binary is an MSB flip.
  assign s_c       = {~adc_data_in[IN_W-1], adc_data_in[IN_W-2:0]};
  assign sum_c     = acc + ACC_W'(s_c);
  assign sum_ext_c = 32'(sum_c);
  assign scaled_c  = (sum_ext_c <<< SHL) >>> SHR;
  assign last_c    = adc_valid_in && (dcnt == DCNT_LAST);

  // Accumulator and registered push toward the FIFO
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      acc       <= '0;
      dcnt      <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      push_q <= 1'b0;
      if (last_c) begin
        push_q    <= 1'b1;
        push_data <= 16'(scaled_c);
        acc       <= '0;
        dcnt      <= '0;
      end else if (adc_valid_in) begin
        acc  <= sum_c;
        dcnt <= dcnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pacing FSM: PRIME until half full, then strobe every PERIOD clocks forever
  // ---------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          strobe_c;

  // State and period counter registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= S_PRIME;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  // Next state, period count and strobe request
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = '0;
    strobe_c  = 1'b0;
    case (state)
      S_PRIME: begin
        if (fifo_level_out >= LVL_PRIME) state_nxt = S_RUN;
      end
      S_RUN: begin
        strobe_c = (pcnt == PCNT_LAST);
        pcnt_nxt = strobe_c ? '0 : (pcnt + PW'(1));
      end
      default: state_nxt = S_PRIME;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_c;
  logic          push_ok_c;

  assign pop_c     = strobe_c && (fifo_level_out != '0);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok_c = push_q && ((fifo_level_out != LVL_FULL) || pop_c);

  // Storage array (no reset needed; occupancy tracks validity)
  always_ff @(posedge clk_in) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy, strobe output and sticky flags
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level_out <= '0;
      ready_out      <= 1'b0;
      x_out          <= '0;
      overflow_out   <= 1'b0;
      underflow_out  <= 1'b0;
    end else begin
      ready_out <= strobe_c;
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (push_q && !push_ok_c) overflow_out <= 1'b1;
      if (pop_c) begin
        x_out  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end else if (strobe_c) begin
        underflow_out <= 1'b1;
`ifdef PACER_ZERO_FILL_EN
        x_out <= '0;
`else
        x_out <= x_out;
`endif
      end
      case ({push_ok_c, pop_c})
        2'b10:   fifo_level_out <= fifo_level_out + LW'(1);
        2'b01:   fifo_level_out <= fifo_level_out - LW'(1);
        default: fifo_level_out <= fifo_level_out;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_pacer.sv
// Self-checking bench for adc_sample_pacer.
// The stimulus side models decimation and scaling arithmetically and queues each
// expected word. The monitor pops one expected word per ready_out strobe and also
// checks the strobe spacing and the underflow flag.

module tb_adc_sample_pacer;

  localparam int unsigned PERIOD     = 128;
  localparam int unsigned DECIM      = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned IN_W       = 12;
  localparam int          SH         = 16 - IN_W - $clog2(DECIM);
  localparam int          HALF       = 1 << (IN_W - 1);

  logic                   clk = 1'b0;
  logic                   rst_in;
  logic                   adc_valid;
  logic [IN_W-1:0]        adc_data;
  logic                   ready_out;
  logic signed [15:0]     x_out;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                   overflow_out;
  logic                   underflow_out;

  adc_sample_pacer #(
    .PERIOD(PERIOD), .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH), .IN_W(IN_W)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .adc_valid_in  (adc_valid),
    .adc_data_in   (adc_data),
    .ready_out     (ready_out),
    .x_out         (x_out),
    .fifo_level_out(fifo_level),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard / model state
  int queue_exp[$];
  int m_acc = 0;
  int m_cnt = 0;
  bit sb_on = 1'b1;
  int last_x = 0;
  bit exp_unf = 1'b0;
  int prev_x = -32768;
  int lvl_max = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_strobe = -1;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int scale(input int a);
    if (SH >= 0) return a * (1 << SH);
    else         return a >>> (-SH);
  endfunction

  task automatic model_update(input logic [IN_W-1:0] code);
    if (sb_on) begin
      m_acc += int'(code) - HALF;
      m_cnt++;
      if (m_cnt == int'(DECIM)) begin
        queue_exp.push_back(scale(m_acc));
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  // One valid cycle followed by gap-1 idle cycles; called and returns at a negedge.
  task automatic send(input logic [IN_W-1:0] code, input int gap);
    adc_data  = code;
    adc_valid = 1'b1;
    model_update(code);
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_in    = 1'b0;
    adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    queue_exp.delete();
    m_acc = 0; m_cnt = 0; last_x = 0; exp_unf = 1'b0;
    prev_x = -32768; lvl_max = 0; strobe_cnt = 0; last_strobe = -1;
    chk({tag, "_ready"}, 32'(ready_out), 0);
    chk({tag, "_x"}, 32'(x_out), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(overflow_out), 0);
    chk({tag, "_unf"}, 32'(underflow_out), 0);
    rst_in = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    int e;
    cyc++;
    if (rst_in) begin
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (ready_out) begin
        strobe_cnt++;
        if (last_strobe >= 0) chk("period", cyc - last_strobe, PERIOD);
        last_strobe = cyc;
        if (sb_on) begin
          if (queue_exp.size() > 0) begin
            e = queue_exp.pop_front();
            chk("x_out", 32'(x_out), e);
            last_x = e;
          end else begin
            exp_unf = 1'b1;
`ifdef PACER_ZERO_FILL_EN
            chk("x_underflow", 32'(x_out), 0);
`else
            chk("x_underflow", 32'(x_out), last_x);
`endif
          end
          chk("underflow_flag", 32'(underflow_out), 32'(exp_unf));
        end else begin
          chk("ramp_monotonic", (int'(x_out) >= prev_x) ? 1 : 0, 1);
          prev_x = int'(x_out);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [IN_W-1:0] ramp;
    rst_in    = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    @(negedge clk);

    // Reset state
    do_reset("por");

    // Conversion: groups of full-scale high and low, one decimated word per PERIOD
    for (int g = 0; g < 16; g++)
      for (int k = 0; k < int'(DECIM); k++)
        send((g % 2 == 0) ? 12'hFFF : 12'h000, PERIOD / DECIM);

    // Reset mid-stream discards buffered data and stops strobes
    do_reset("mid");
    repeat (2 * PERIOD) @(negedge clk);
    chk("mid_no_strobe", strobe_cnt, 0);
    chk("mid_level", 32'(fifo_level), 0);

    // Midscale input gives zero output with no flags
    do_reset("t3");
    for (int i = 0; i < 12 * int'(DECIM); i++) send(12'h800, PERIOD / DECIM);
    chk("t3_ovf", 32'(overflow_out), 0);
    chk("t3_unf", 32'(underflow_out), 0);
    chk("t3_strobes", (strobe_cnt >= 6) ? 1 : 0, 1);

    // Underflow: prime with four words, then starve
    do_reset("t5");
    send(12'h900, 1); send(12'h900, 1); send(12'h900, 1); send(12'h900, 1);
    send(12'hA37, 1); send(12'hA37, 1); send(12'hA37, 1); send(12'hA37, 1);
    send(12'h700, 1); send(12'h6FF, 1); send(12'h700, 1); send(12'h701, 1);
    send(12'h123, 1); send(12'h004, 1); send(12'h7FE, 1); send(12'h3C0, 1);
    repeat (6 * PERIOD) @(negedge clk);
    chk("t5_unf", 32'(underflow_out), 1);
    chk("t5_ovf", 32'(overflow_out), 0);
    chk("t5_strobes", (strobe_cnt >= 5) ? 1 : 0, 1);

    // Overflow: a valid every clock with a ramp input
    do_reset("t4");
    sb_on = 1'b0;
    ramp  = '0;
    for (int t = 0; t < 2 * int'(PERIOD) && !overflow_out; t++) begin
      send(ramp, 1);
      ramp = ramp + 1'b1;
    end
    chk("t4_ovf", 32'(overflow_out), 1);
    for (int t = 0; t < 3 * int'(PERIOD); t++) begin
      send(ramp, 1);
      ramp = ramp + 1'b1;
    end
    chk("t4_level_max", lvl_max, FIFO_DEPTH);
    chk("t4_unf", 32'(underflow_out), 0);
    chk("t4_strobes", (strobe_cnt >= 2) ? 1 : 0, 1);
    sb_on = 1'b1;

    // Push aligned with a pop while full: accepted, no overflow
    do_reset("t6");
    for (int i = 0; i < int'(FIFO_DEPTH * DECIM); i++) send(IN_W'(16 * i + 3), 1);
    found = 1'b0;
    for (int i = 0; i < 3 * int'(PERIOD) && !found; i++) begin
      @(negedge clk);
      if (ready_out) found = 1'b1;
    end
    chk("t6_first_strobe", 32'(found), 1);
    chk("t6_level_after_pop", 32'(fifo_level), FIFO_DEPTH - 1);
    // Next pop edge is PERIOD edges ahead; the last valid lands one edge before it.
    for (int k = 0; k < int'(PERIOD) - 1; k++) begin
      if (k < 4 || k >= int'(PERIOD) - 5) begin
        adc_data  = IN_W'(1000 + k);
        adc_valid = 1'b1;
        model_update(adc_data);
      end else begin
        adc_valid = 1'b0;
      end
      if (k == 10) chk("t6_level_full", 32'(fifo_level), FIFO_DEPTH);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    @(negedge clk);
    chk("t6_strobe", 32'(ready_out), 1);
    chk("t6_level", 32'(fifo_level), FIFO_DEPTH);
    chk("t6_ovf", 32'(overflow_out), 0);
    repeat (PERIOD + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
